// File: rtl/dmem_arb_pkg.sv
// Shared types and default parameters for the dmem scan arbiter.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W       = 10;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_LEN_W        = 8;
    localparam int DEF_STARVE_LIMIT = 64;

    // Scan engine FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_scan_arbiter_starve_counter.sv
// Saturating count of consecutive CPU-owned cycles during a scan.
// at_limit_o fires in the cycle whose increment brings (or keeps) the
// count at STARVE_LIMIT, so a flag registered from it is visible in the
// cycle right after the limiting CPU cycle.
module starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1  = CNT_W'(STARVE_LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = inc_i && !clr_i && (cnt_q >= LIMIT_M1);

endmodule

// File: rtl/dmem_scan_arbiter.sv
// Shares the dmem port between the CPU (absolute priority, never stalled)
// and a background engine that copies a window of words into a snapshot
// stream using only the cycles where the CPU does not select dmem.
//
// Handshake: there is no back-pressure. scan_start is a one-cycle request,
// accepted only in IDLE; snap_valid qualifies snap_index/snap_data for
// exactly one cycle per word; scan_done is a one-cycle completion pulse.
module dmem_scan_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int LEN_W        = DEF_LEN_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              scan_start,
    input  logic [ADDR_W-1:0] scan_base,
    input  logic [LEN_W-1:0]  scan_len,
    output logic              snap_valid,
    output logic [LEN_W-1:0]  snap_index,
    output logic [DATA_W-1:0] snap_data,
    output logic              scan_busy,
    output logic              scan_done,
    output logic              starve,
    output logic              torn,
    output logic [1:0]        dbg_state
);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  ptr_q, ptr_d;
    logic              snap_valid_q, snap_valid_d;
    logic [LEN_W-1:0]  snap_index_q, snap_index_d;
    logic [DATA_W-1:0] snap_data_q, snap_data_d;
    logic              scan_busy_q, scan_busy_d;
    logic              scan_done_q, scan_done_d;
    logic              starve_q, starve_d;
    logic              torn_q, torn_d;

    logic              scan_free;
    logic              cpu_in_scan;
    logic              at_limit;
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] wr_offset;
    logic              tear_hit;

    // A scan cycle is free when the CPU leaves the port alone.
    assign scan_free   = (state_q == ST_SCAN) && !cpu_cs;
    assign cpu_in_scan = (state_q == ST_SCAN) && cpu_cs;

    // Window addressing and tear detection wrap modulo 2^ADDR_W.
    assign scan_addr = base_q + ADDR_W'(ptr_q);
    assign wr_offset = cpu_addr - base_q;
    assign tear_hit  = ({{LEN_W{1'b0}}, wr_offset} < {{ADDR_W{1'b0}}, ptr_q});

    // Port mux: CPU owns the port except on free SCAN cycles; the scan never writes.
    assign mem_addr  = scan_free ? scan_addr : cpu_addr;
    assign mem_we    = cpu_cs & cpu_we;
    assign mem_wdata = cpu_wdata;
    assign cpu_rdata = mem_rdata;

    starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (cpu_in_scan),
        .clr_i      (!cpu_in_scan),
        .at_limit_o (at_limit)
    );

    // Next-state, pointer, snapshot and flag logic.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        ptr_d        = ptr_q;
        snap_valid_d = 1'b0;
        snap_index_d = snap_index_q;
        snap_data_d  = snap_data_q;
        starve_d     = starve_q;
        torn_d       = torn_q;
        case (state_q)
            ST_IDLE: begin
                if (scan_start) begin
                    base_d   = scan_base;
                    len_d    = scan_len;
                    ptr_d    = '0;
                    starve_d = 1'b0;
                    torn_d   = 1'b0;
                    state_d  = (scan_len == '0) ? ST_DONE : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!cpu_cs) begin
                    snap_valid_d = 1'b1;
                    snap_index_d = ptr_q;
                    snap_data_d  = mem_rdata;
                    ptr_d        = ptr_q + LEN_W'(1);
                    if (ptr_q == len_q - LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end else if (cpu_we && tear_hit) begin
                    torn_d = 1'b1;
                end
                if (at_limit) begin
                    starve_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        scan_busy_d = (state_d == ST_SCAN);
        scan_done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset aborts any scan in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            ptr_q        <= '0;
            snap_valid_q <= 1'b0;
            snap_index_q <= '0;
            snap_data_q  <= '0;
            scan_busy_q  <= 1'b0;
            scan_done_q  <= 1'b0;
            starve_q     <= 1'b0;
            torn_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            ptr_q        <= ptr_d;
            snap_valid_q <= snap_valid_d;
            snap_index_q <= snap_index_d;
            snap_data_q  <= snap_data_d;
            scan_busy_q  <= scan_busy_d;
            scan_done_q  <= scan_done_d;
            starve_q     <= starve_d;
            torn_q       <= torn_d;
        end
    end

    assign snap_valid = snap_valid_q;
    assign snap_index = snap_index_q;
    assign snap_data  = snap_data_q;
    assign scan_busy  = scan_busy_q;
    assign scan_done  = scan_done_q;
    assign starve     = starve_q;
    assign torn       = torn_q;
    assign dbg_state  = state_q;

endmodule
